sram_like_arbiter: RTL and testbench

- Shares one SRAM-like master port between the instruction-fetch requester and the MEM-stage data requester.
- Data requests take priority. Up to OUTST_DEPTH accepted transactions may be outstanding, and each response is routed back to its owner in order.
- An exception flush cancels in-flight fetch responses without disturbing data transactions.
- Sits between the core's inst/data SRAM-like ports and the single bus bridge.

---
 rtl/sram_like_arbiter_pkg.sv | 20 ++
 rtl/arb_owner_fifo.sv | 75 +++++++
 rtl/sram_like_arbiter.sv | 155 +++++++++++++++
 tb/tb_sram_like_arbiter.sv | 332 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_like_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sram_like_arbiter_pkg
// Description : Shared types for the inst/data SRAM-like arbiter.
// Revision    : 1.0
// ============================================================================
package sram_like_arbiter_pkg;

    typedef enum logic {
        OWN_INST = 1'b0,
        OWN_DATA = 1'b1
    } req_owner_t;

    typedef struct packed {
        req_owner_t owner;
        logic       discard;
    } owner_entry_t;

endpackage
`default_nettype wire

// File: rtl/arb_owner_fifo.sv
`default_nettype none
// ============================================================================
// Module      : arb_owner_fifo
// Description : Circular FIFO of outstanding-transaction owners; a flush marks
//               every INST entry so its response is dropped.
// Revision    : 1.0
// ============================================================================
module arb_owner_fifo
    import sram_like_arbiter_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               i_push,
    input  owner_entry_t       i_push_entry,
    input  logic               i_pop,
    input  logic               i_flush_inst,
    output owner_entry_t       o_head,
    output logic [CNT_W-1:0]   o_count,
    output logic               o_full,
    output logic               o_empty
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    owner_entry_t     r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             w_push;
    logic             w_pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign o_full  = (r_count == CNT_W'(DEPTH));
    assign o_empty = (r_count == '0);
    assign o_count = r_count;
    assign o_head  = r_mem[r_rd_ptr];
    assign w_push  = i_push & ~o_full;
    assign w_pop   = i_pop & ~o_empty;

    // Stale slots may also get discard set by a flush; a push overwrites them whole.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (w_push && (r_wr_ptr == PTR_W'(i))) begin
                    r_mem[i] <= i_push_entry;
                end else if (i_flush_inst && (r_mem[i].owner == OWN_INST)) begin
                    r_mem[i].discard <= 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= ptr_inc(r_wr_ptr);
            if (w_pop)  r_rd_ptr <= ptr_inc(r_rd_ptr);
            if (w_push && !w_pop)      r_count <= r_count + 1'b1;
            else if (!w_push && w_pop) r_count <= r_count - 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/sram_like_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : sram_like_arbiter
// Description : Shares one SRAM-like master port between fetch and MEM-stage
//               requesters; data has priority, responses return in order.
// Revision    : 1.0
// ============================================================================
module sram_like_arbiter
    import sram_like_arbiter_pkg::*;
#(
    parameter int OUTST_DEPTH = 2
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        inst_req,
    input  logic        inst_wr,
    input  logic [1:0]  inst_size,
    input  logic [31:0] inst_addr,
    input  logic [31:0] inst_wdata,
    output logic        inst_addr_ok,
    output logic        inst_data_ok,
    output logic [31:0] inst_rdata,
    input  logic        data_req,
    input  logic        data_wr,
    input  logic [1:0]  data_size,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    output logic        data_addr_ok,
    output logic        data_data_ok,
    output logic [31:0] data_rdata,
    input  logic        flush,
    output logic        m_req,
    output logic        m_wr,
    output logic [1:0]  m_size,
    output logic [31:0] m_addr,
    output logic [31:0] m_wdata,
    input  logic        m_addr_ok,
    input  logic        m_data_ok,
    input  logic [31:0] m_rdata,
    output logic        proto_err
);

    localparam int CNT_W = $clog2(OUTST_DEPTH + 1);

    logic             r_lock;
    req_owner_t       r_lock_owner;
    logic             r_proto_err;
    logic             w_sel_valid;
    req_owner_t       w_sel;
    logic             w_issue;
    logic             w_accept;
    logic             w_pop;
    logic             w_resp;
    logic             w_full;
    logic             w_empty;
    logic [CNT_W-1:0] w_count;
    owner_entry_t     w_head;
    owner_entry_t     w_push_entry;

    always_comb begin
        w_sel_valid = 1'b0;
        w_sel       = OWN_DATA;
        if (r_lock) begin
            w_sel_valid = 1'b1;
            w_sel       = r_lock_owner;
        end else if (data_req) begin
            w_sel_valid = 1'b1;
            w_sel       = OWN_DATA;
        end else if (inst_req) begin
            w_sel_valid = 1'b1;
            w_sel       = OWN_INST;
        end
    end

    // Outputs are forced low while reset is asserted, independent of the clock.
    assign w_issue  = resetn & w_sel_valid & ~w_full;
    assign w_accept = w_issue & m_addr_ok;
    assign m_req    = w_issue;

    always_comb begin
        m_wr    = 1'b0;
        m_size  = '0;
        m_addr  = '0;
        m_wdata = '0;
        if (resetn && w_sel_valid) begin
            if (w_sel == OWN_DATA) begin
                m_wr    = data_wr;
                m_size  = data_size;
                m_addr  = data_addr;
                m_wdata = data_wdata;
            end else begin
                m_wr    = inst_wr;
                m_size  = inst_size;
                m_addr  = inst_addr;
                m_wdata = inst_wdata;
            end
        end
    end

    assign data_addr_ok = w_accept & (w_sel == OWN_DATA);
    assign inst_addr_ok = w_accept & (w_sel == OWN_INST);

    assign w_push_entry.owner   = w_sel;
    assign w_push_entry.discard = flush & (w_sel == OWN_INST);

    // A flush also kills an INST head popping in the same cycle.
    assign w_pop  = m_data_ok & ~w_empty;
    assign w_resp = resetn & w_pop & ~w_head.discard
                    & ~(flush & (w_head.owner == OWN_INST));
    assign inst_data_ok = w_resp & (w_head.owner == OWN_INST);
    assign data_data_ok = w_resp & (w_head.owner == OWN_DATA);
    assign inst_rdata   = m_rdata;
    assign data_rdata   = m_rdata;
    assign proto_err    = r_proto_err;

    arb_owner_fifo #(
        .DEPTH (OUTST_DEPTH),
        .CNT_W (CNT_W)
    ) u_owner_fifo (
        .clk          (clk),
        .rst_n        (resetn),
        .i_push       (w_accept),
        .i_push_entry (w_push_entry),
        .i_pop        (w_pop),
        .i_flush_inst (flush),
        .o_head       (w_head),
        .o_count      (w_count),
        .o_full       (w_full),
        .o_empty      (w_empty)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_lock       <= 1'b0;
            r_lock_owner <= OWN_INST;
        end else if (flush && r_lock && (r_lock_owner == OWN_INST)) begin
            r_lock <= 1'b0;
        end else if (w_issue && !m_addr_ok) begin
            r_lock       <= 1'b1;
            r_lock_owner <= w_sel;
        end else if (w_accept) begin
            r_lock <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_proto_err <= 1'b0;
        end else if (m_data_ok && w_empty) begin
            r_proto_err <= 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_sram_like_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_sram_like_arbiter
// Description : Directed scenarios plus randomized traffic against a queue model.
// Revision    : 1.0
// ============================================================================
module tb_sram_like_arbiter;

    localparam int DEPTH = 2;

    typedef struct {
        bit own_data;
        bit disc;
    } ent_t;

    logic        clk = 1'b0;
    logic        resetn;
    logic        inst_req, inst_wr, data_req, data_wr, flush;
    logic [1:0]  inst_size, data_size, m_size;
    logic [31:0] inst_addr, inst_wdata, data_addr, data_wdata;
    logic        inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok;
    logic [31:0] inst_rdata, data_rdata, m_addr, m_wdata, m_rdata;
    logic        m_req, m_wr, m_addr_ok, m_data_ok, proto_err;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    sram_like_arbiter #(.OUTST_DEPTH(DEPTH)) dut (
        .clk(clk), .resetn(resetn),
        .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size),
        .inst_addr(inst_addr), .inst_wdata(inst_wdata),
        .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
        .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
        .data_addr(data_addr), .data_wdata(data_wdata),
        .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
        .flush(flush),
        .m_req(m_req), .m_wr(m_wr), .m_size(m_size), .m_addr(m_addr), .m_wdata(m_wdata),
        .m_addr_ok(m_addr_ok), .m_data_ok(m_data_ok), .m_rdata(m_rdata),
        .proto_err(proto_err)
    );

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        inst_req = 0; inst_wr = 0; inst_size = 0; inst_addr = 0; inst_wdata = 0;
        data_req = 0; data_wr = 0; data_size = 0; data_addr = 0; data_wdata = 0;
        flush = 0; m_addr_ok = 0; m_data_ok = 0; m_rdata = 0;
    endtask

    task automatic test_reset();
        clear_inputs();
        resetn = 0;
        data_req = 1; data_addr = 32'h55; m_addr_ok = 1; m_data_ok = 1;
        #1;
        checks++; if ({m_req, m_wr, m_size, m_addr, m_wdata} !== 67'h0) begin
            errors++; $display("FAIL reset_m: got %h want 0", {m_req, m_wr, m_size, m_addr, m_wdata}); end
        checks++; if ({inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok, proto_err} !== 5'b0) begin
            errors++; $display("FAIL reset_ok: got %b want 00000",
                {inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok, proto_err}); end
        next_cycle();
        clear_inputs();
        resetn = 1;
        next_cycle();
    endtask

    task automatic test_single_read();
        data_req = 1; data_addr = 32'h1000; data_size = 2; m_addr_ok = 1;
        #1;
        checks++; if ({m_req, m_addr, data_addr_ok, inst_addr_ok} !== {1'b1, 32'h1000, 2'b10}) begin
            errors++; $display("FAIL single_issue: got %h want %h",
                {m_req, m_addr, data_addr_ok, inst_addr_ok}, {1'b1, 32'h1000, 2'b10}); end
        next_cycle();
        data_req = 0; m_addr_ok = 0;
        for (int c = 1; c < 3; c++) begin
            #1;
            checks++; if ({m_req, data_data_ok, inst_data_ok} !== 3'b0) begin
                errors++; $display("FAIL single_wait%0d: got %b want 000", c, {m_req, data_data_ok, inst_data_ok}); end
            next_cycle();
        end
        m_data_ok = 1; m_rdata = 32'hDEADBEEF;
        #1;
        checks++; if ({data_data_ok, inst_data_ok, data_rdata} !== {2'b10, 32'hDEADBEEF}) begin
            errors++; $display("FAIL single_resp: got %h want %h",
                {data_data_ok, inst_data_ok, data_rdata}, {2'b10, 32'hDEADBEEF}); end
        next_cycle();
        clear_inputs();
    endtask

    task automatic test_priority();
        inst_req = 1; inst_addr = 32'hA000; data_req = 1; data_addr = 32'hB000; m_addr_ok = 1;
        #1;
        checks++; if ({m_addr, data_addr_ok, inst_addr_ok} !== {32'hB000, 2'b10}) begin
            errors++; $display("FAIL prio_data_first: got %h want %h", {m_addr, data_addr_ok, inst_addr_ok}, {32'hB000, 2'b10}); end
        next_cycle();
        data_req = 0;
        #1;
        checks++; if ({m_addr, data_addr_ok, inst_addr_ok} !== {32'hA000, 2'b01}) begin
            errors++; $display("FAIL prio_inst_next: got %h want %h", {m_addr, data_addr_ok, inst_addr_ok}, {32'hA000, 2'b01}); end
        next_cycle();
        inst_req = 0; m_addr_ok = 0; m_data_ok = 1; m_rdata = 32'h1111;
        #1;
        checks++; if ({data_data_ok, inst_data_ok} !== 2'b10) begin
            errors++; $display("FAIL prio_resp1: got %b want 10", {data_data_ok, inst_data_ok}); end
        next_cycle();
        m_rdata = 32'h2222;
        #1;
        checks++; if ({data_data_ok, inst_data_ok, inst_rdata} !== {2'b01, 32'h2222}) begin
            errors++; $display("FAIL prio_resp2: got %h want %h", {data_data_ok, inst_data_ok, inst_rdata}, {2'b01, 32'h2222}); end
        next_cycle();
        clear_inputs();
    endtask

    task automatic test_lock();
        inst_req = 1; inst_addr = 32'hC000; m_addr_ok = 0;
        #1;
        checks++; if ({m_req, m_addr, inst_addr_ok} !== {1'b1, 32'hC000, 1'b0}) begin
            errors++; $display("FAIL lock_c0: got %h want %h", {m_req, m_addr, inst_addr_ok}, {1'b1, 32'hC000, 1'b0}); end
        next_cycle();
        data_req = 1; data_addr = 32'hD000;
        #1;
        checks++; if ({m_addr, data_addr_ok} !== {32'hC000, 1'b0}) begin
            errors++; $display("FAIL lock_hold: got %h want %h", {m_addr, data_addr_ok}, {32'hC000, 1'b0}); end
        next_cycle();
        m_addr_ok = 1;
        #1;
        checks++; if ({m_addr, inst_addr_ok, data_addr_ok} !== {32'hC000, 2'b10}) begin
            errors++; $display("FAIL lock_accept: got %h want %h", {m_addr, inst_addr_ok, data_addr_ok}, {32'hC000, 2'b10}); end
        next_cycle();
        inst_req = 0;
        #1;
        checks++; if ({m_addr, inst_addr_ok, data_addr_ok} !== {32'hD000, 2'b01}) begin
            errors++; $display("FAIL lock_data_after: got %h want %h", {m_addr, inst_addr_ok, data_addr_ok}, {32'hD000, 2'b01}); end
        next_cycle();
        data_req = 0; m_addr_ok = 0; m_data_ok = 1;
        #1;
        checks++; if ({inst_data_ok, data_data_ok} !== 2'b10) begin
            errors++; $display("FAIL lock_resp1: got %b want 10", {inst_data_ok, data_data_ok}); end
        next_cycle();
        #1;
        checks++; if ({inst_data_ok, data_data_ok} !== 2'b01) begin
            errors++; $display("FAIL lock_resp2: got %b want 01", {inst_data_ok, data_data_ok}); end
        next_cycle();
        clear_inputs();
    endtask

    task automatic test_full();
        m_addr_ok = 1;
        for (int k = 0; k < DEPTH; k++) begin
            data_req = 1; data_addr = 32'hE000 + k;
            #1;
            checks++; if (data_addr_ok !== 1'b1) begin
                errors++; $display("FAIL full_fill%0d: got %b want 1", k, data_addr_ok); end
            next_cycle();
        end
        data_addr = 32'hE0FF;
        #1;
        checks++; if ({m_req, data_addr_ok} !== 2'b00) begin
            errors++; $display("FAIL full_block: got %b want 00", {m_req, data_addr_ok}); end
        next_cycle();
        m_data_ok = 1;
        #1;
        checks++; if ({m_req, data_data_ok} !== 2'b01) begin
            errors++; $display("FAIL full_no_bypass: got %b want 01", {m_req, data_data_ok}); end
        next_cycle();
        m_data_ok = 0;
        #1;
        checks++; if ({m_req, data_addr_ok, m_addr} !== {2'b11, 32'hE0FF}) begin
            errors++; $display("FAIL full_resume: got %h want %h", {m_req, data_addr_ok, m_addr}, {2'b11, 32'hE0FF}); end
        next_cycle();
        data_req = 0; m_addr_ok = 0; m_data_ok = 1;
        for (int k = 0; k < DEPTH; k++) begin
            #1;
            checks++; if (data_data_ok !== 1'b1) begin
                errors++; $display("FAIL full_drain%0d: got %b want 1", k, data_data_ok); end
            next_cycle();
        end
        clear_inputs();
    endtask

    task automatic test_flush();
        inst_req = 1; inst_addr = 32'hF000; m_addr_ok = 1;
        next_cycle();
        inst_req = 0; data_req = 1; data_addr = 32'hF100;
        next_cycle();
        data_req = 0; m_addr_ok = 0; flush = 1;
        next_cycle();
        flush = 0; m_data_ok = 1;
        #1;
        checks++; if ({inst_data_ok, data_data_ok} !== 2'b00) begin
            errors++; $display("FAIL flush_inst_dropped: got %b want 00", {inst_data_ok, data_data_ok}); end
        next_cycle();
        #1;
        checks++; if ({inst_data_ok, data_data_ok} !== 2'b01) begin
            errors++; $display("FAIL flush_data_kept: got %b want 01", {inst_data_ok, data_data_ok}); end
        next_cycle();
        m_data_ok = 0; inst_req = 1; m_addr_ok = 1;
        next_cycle();
        inst_req = 0; m_addr_ok = 0; flush = 1; m_data_ok = 1;
        #1;
        checks++; if ({inst_data_ok, data_data_ok} !== 2'b00) begin
            errors++; $display("FAIL flush_same_cycle_pop: got %b want 00", {inst_data_ok, data_data_ok}); end
        next_cycle();
        clear_inputs();
        #1;
        checks++; if (proto_err !== 1'b0) begin
            errors++; $display("FAIL flush_no_err: got %b want 0", proto_err); end
        next_cycle();
    endtask

    task automatic test_error_reset();
        m_data_ok = 1;
        #1;
        checks++; if ({inst_data_ok, data_data_ok} !== 2'b00) begin
            errors++; $display("FAIL err_no_ok: got %b want 00", {inst_data_ok, data_data_ok}); end
        next_cycle();
        m_data_ok = 0;
        for (int c = 0; c < 2; c++) begin
            #1;
            checks++; if (proto_err !== 1'b1) begin
                errors++; $display("FAIL err_sticky%0d: got %b want 1", c, proto_err); end
            next_cycle();
        end
        data_req = 1; data_addr = 32'h7000; m_addr_ok = 1;
        next_cycle();
        data_req = 0; inst_req = 1; inst_addr = 32'h7100; m_addr_ok = 0;
        next_cycle();
        resetn = 0;
        #1;
        checks++; if ({m_req, m_addr, inst_addr_ok, data_addr_ok, proto_err} !== 36'h0) begin
            errors++; $display("FAIL rst_mid: got %h want 0", {m_req, m_addr, inst_addr_ok, data_addr_ok, proto_err}); end
        next_cycle();
        clear_inputs();
        resetn = 1;
        next_cycle();
        m_data_ok = 1;
        #1;
        checks++; if ({data_data_ok, inst_data_ok} !== 2'b00) begin
            errors++; $display("FAIL rst_stale_resp: got %b want 00", {data_data_ok, inst_data_ok}); end
        next_cycle();
        m_data_ok = 0;
        #1;
        checks++; if (proto_err !== 1'b1) begin
            errors++; $display("FAIL rst_stale_err: got %b want 1", proto_err); end
        resetn = 0;
        next_cycle();
        resetn = 1;
        next_cycle();
    endtask

    task automatic test_random(input int n);
        ent_t        q[$];
        bit          lk = 0, lk_data = 0;
        bit          sv, sd, e_mreq, e_acc, e_dok, e_iok, drop_inst, acc_data;
        logic [66:0] e_fields;
        for (int c = 0; c < n + 12; c++) begin
            bit quiet = (c >= n);
            if (!quiet && !inst_req && $urandom_range(0, 2) == 0) begin
                inst_req = 1; inst_wr = 0; inst_size = 2'($urandom);
                inst_addr = $urandom; inst_wdata = $urandom;
            end
            if (!quiet && !data_req && $urandom_range(0, 2) == 0) begin
                data_req = 1; data_wr = 1'($urandom); data_size = 2'($urandom);
                data_addr = $urandom; data_wdata = $urandom;
            end
            m_addr_ok = quiet ? 1'b1 : 1'($urandom_range(0, 1));
            m_data_ok = (q.size() > 0) && (quiet || $urandom_range(0, 2) == 0);
            m_rdata   = $urandom;
            flush     = !quiet && ($urandom_range(0, 9) == 0);

            sv = lk || data_req || inst_req;
            sd = lk ? lk_data : data_req;
            e_mreq = sv && (q.size() < DEPTH);
            e_acc  = e_mreq && m_addr_ok;
            if (!sv)     e_fields = '0;
            else if (sd) e_fields = {data_wr, data_size, data_addr, data_wdata};
            else         e_fields = {inst_wr, inst_size, inst_addr, inst_wdata};
            e_dok = 0; e_iok = 0;
            if (m_data_ok && q.size() > 0) begin
                if (q[0].own_data) e_dok = 1;
                else if (!q[0].disc && !flush) e_iok = 1;
            end
            #1;
            checks++; if (m_req !== e_mreq) begin
                errors++; $display("FAIL rnd_m_req c%0d: got %b want %b", c, m_req, e_mreq); end
            checks++; if ({m_wr, m_size, m_addr, m_wdata} !== e_fields) begin
                errors++; $display("FAIL rnd_fields c%0d: got %h want %h", c, {m_wr, m_size, m_addr, m_wdata}, e_fields); end
            checks++; if ({data_addr_ok, inst_addr_ok} !== {e_acc && sd, e_acc && !sd}) begin
                errors++; $display("FAIL rnd_addr_ok c%0d: got %b want %b", c, {data_addr_ok, inst_addr_ok}, {e_acc && sd, e_acc && !sd}); end
            checks++; if ({data_data_ok, inst_data_ok} !== {e_dok, e_iok}) begin
                errors++; $display("FAIL rnd_data_ok c%0d: got %b want %b", c, {data_data_ok, inst_data_ok}, {e_dok, e_iok}); end
            checks++; if (data_rdata !== m_rdata || inst_rdata !== m_rdata) begin
                errors++; $display("FAIL rnd_rdata c%0d: got %h/%h want %h", c, data_rdata, inst_rdata, m_rdata); end

            if (flush) foreach (q[i]) if (!q[i].own_data) q[i].disc = 1;
            if (m_data_ok && q.size() > 0) void'(q.pop_front());
            if (e_acc) q.push_back('{sd, flush && !sd});
            if (flush && lk && !lk_data) lk = 0;
            else if (e_mreq && !m_addr_ok) begin lk = 1; lk_data = sd; end
            else if (e_acc) lk = 0;
            acc_data  = sd;
            drop_inst = flush && !(lk && !lk_data) && ($urandom_range(0, 1) == 1);
            next_cycle();
            if (e_acc && acc_data) data_req = 0;
            if ((e_acc && !acc_data) || drop_inst) inst_req = 0;
        end
        clear_inputs();
        #1;
        checks++; if ({m_req, proto_err} !== 2'b00) begin
            errors++; $display("FAIL rnd_end_idle: got %b want 00", {m_req, proto_err}); end
        next_cycle();
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_priority();
        test_lock();
        test_full();
        test_flush();
        test_error_reset();
        test_random(400);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
